// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared constants for the memory-port arbiter and its timeout counter:
// the memory access width encoding, the exception code width and values,
// and the arbiter state encoding.
package mem_port_arbiter_pkg;

  localparam int EXCEPTION_LEN = 4;

  localparam logic [1:0] MEM_WIDTH_NONE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd1;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd2;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd3;

  localparam logic [EXCEPTION_LEN-1:0] EXCEP_NONE               = 4'd0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_STORE_ACCESS_FAULT = 4'd7;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_BUSY_FETCH = 2'd1,
    ARB_BUSY_DATA  = 2'd2
  } arb_state_e;

  // Fault reported when a transaction is abandoned. Fetches are latched as
  // reads, so they report a load fault.
  function automatic logic [EXCEPTION_LEN-1:0] access_fault(input logic is_read);
    return is_read ? EXCEP_LOAD_ACCESS_FAULT : EXCEP_STORE_ACCESS_FAULT;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// mem_timeout_counter
// Counts cycles a transaction spends waiting for the memory and flags the
// cycle on which the wait reaches TIMEOUT_CYCLES.
//   clk, rst     : clock, synchronous active-high reset
//   clear_In     : zero the count (held while the arbiter is idle)
//   enable_In    : one more waiting cycle this cycle
//   expired_Out  : this enabled cycle is waiting cycle number TIMEOUT_CYCLES
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_In,
  input  logic enable_In,
  output logic expired_Out
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_In) begin
      cnt_d = '0;
    end else if (enable_In) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // The count holds the waiting cycles already completed, so the
  // TIMEOUT_CYCLES-th one is the current cycle when it equals TIMEOUT_CYCLES-1.
  assign expired_Out = enable_In && !clear_In &&
                       (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single RAMAccess port between instruction fetch and the
// executor's load/store unit. One requester is granted per transaction, its
// request is latched onto the mem* outputs, and the response (data, OK,
// exception) is routed back to that requester only.
//   fetch*  : word-read requester; fetchValid_In held until fetchOK_Out
//   data*   : load/store requester; dataValid_In held until dataOK_Out
//   mem*    : registered request to RAMAccess and its response
// Fairness: after MAX_DATA_STREAK consecutive data grants with fetch
// waiting, fetch wins the next contended grant. A transaction whose
// memory never answers is aborted after TIMEOUT_CYCLES with an access fault.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int CNT_WIDTH       = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              fetchAddr_In,
  input  logic                     fetchValid_In,
  output logic [31:0]              fetchData_Out,
  output logic                     fetchOK_Out,
  output logic [EXCEPTION_LEN-1:0] fetchException_Out,
  input  logic [31:0]              dataAddr_In,
  input  logic [31:0]              dataWrite_In,
  input  logic [1:0]               dataWidth_In,
  input  logic                     dataIsRead_In,
  input  logic                     dataValid_In,
  output logic [31:0]              dataRead_Out,
  output logic                     dataOK_Out,
  output logic [EXCEPTION_LEN-1:0] dataException_Out,
  output logic [31:0]              memAddr_Out,
  output logic [31:0]              memData_Out,
  output logic [1:0]               memWidth_Out,
  output logic                     memIsRead_Out,
  output logic                     memValid_Out,
  input  logic [31:0]              memData_In,
  input  logic                     memOK_In,
  input  logic [EXCEPTION_LEN-1:0] memException_In
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  arb_state_e            state_q, state_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic [1:0]            mem_width_q, mem_width_d;
  logic                  mem_is_read_q, mem_is_read_d;
  logic                  mem_valid_q, mem_valid_d;

  logic                     busy;
  logic                     timeout_expired;
  logic                     resp_done;
  logic [31:0]              resp_data;
  logic [EXCEPTION_LEN-1:0] resp_exc;

  assign busy = (state_q != ARB_IDLE);

  mem_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_timeout (
    .clk         (clk),
    .rst         (rst),
    .clear_In    (!busy),
    .enable_In   (busy && !memOK_In),
    .expired_Out (timeout_expired)
  );

  // A real memory answer takes priority over a timeout in the same cycle,
  // because the counter is only enabled while memOK_In is low.
  always_comb begin
    resp_done = 1'b0;
    resp_data = '0;
    resp_exc  = EXCEP_NONE;
    if (busy) begin
      if (memOK_In) begin
        resp_done = 1'b1;
        resp_data = memData_In;
        resp_exc  = memException_In;
      end else if (timeout_expired) begin
        resp_done = 1'b1;
        resp_exc  = access_fault(mem_is_read_q);
      end
    end
  end

  assign fetchOK_Out        = resp_done && (state_q == ARB_BUSY_FETCH);
  assign fetchData_Out      = fetchOK_Out ? resp_data : '0;
  assign fetchException_Out = fetchOK_Out ? resp_exc : EXCEP_NONE;
  assign dataOK_Out         = resp_done && (state_q == ARB_BUSY_DATA);
  assign dataRead_Out       = dataOK_Out ? resp_data : '0;
  assign dataException_Out  = dataOK_Out ? resp_exc : EXCEP_NONE;

  assign memAddr_Out   = mem_addr_q;
  assign memData_Out   = mem_data_q;
  assign memWidth_Out  = mem_width_q;
  assign memIsRead_Out = mem_is_read_q;
  assign memValid_Out  = mem_valid_q;

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    mem_width_d   = mem_width_q;
    mem_is_read_d = mem_is_read_q;
    mem_valid_d   = mem_valid_q;

    case (state_q)
      ARB_IDLE: begin
        // Data wins contention unless fetch has already waited through a
        // full streak of data grants.
        if (dataValid_In &&
            !(fetchValid_In && (streak_q == STREAK_W'(MAX_DATA_STREAK)))) begin
          state_d       = ARB_BUSY_DATA;
          mem_addr_d    = dataAddr_In;
          mem_data_d    = dataWrite_In;
          mem_width_d   = dataWidth_In;
          mem_is_read_d = dataIsRead_In;
          mem_valid_d   = 1'b1;
          if (fetchValid_In && (streak_q != STREAK_W'(MAX_DATA_STREAK))) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (fetchValid_In) begin
          state_d       = ARB_BUSY_FETCH;
          mem_addr_d    = fetchAddr_In;
          mem_data_d    = '0;
          mem_width_d   = MEM_WIDTH_WORD;
          mem_is_read_d = 1'b1;
          mem_valid_d   = 1'b1;
          streak_d      = '0;
        end
      end
      ARB_BUSY_FETCH, ARB_BUSY_DATA: begin
        if (resp_done) begin
          state_d     = ARB_IDLE;
          mem_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase

    // The streak only measures data grants taken while fetch is waiting.
    if (!fetchValid_In) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      streak_q      <= '0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_width_q   <= MEM_WIDTH_NONE;
      mem_is_read_q <= 1'b1;
      mem_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_width_q   <= mem_width_d;
      mem_is_read_q <= mem_is_read_d;
      mem_valid_q   <= mem_valid_d;
    end
  end

endmodule
